cmd_payload_receiver: RTL and testbench

//   Downstream of the per-address command matcher (o_hold).

---
 rtl/cmd_payload_receiver_if.sv | 25 ++
 rtl/cmd_payload_receiver.sv | 130 +++++++++++++
 tb/tb_cmd_payload_receiver.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cmd_payload_receiver_if.sv
// Byte-stream and result bundle between the matcher/UART side and the payload receiver.
// The master side supplies hold, the byte-ready level and the byte. The slave side returns
// the assembled payload and the handshake pulses.
interface cmd_payload_receiver_if #(
    parameter int NUM_BYTES = 4
);
    logic                   hold;
    logic                   ready_read;
    logic [7:0]             rx_byte;
    logic [8*NUM_BYTES-1:0] payload;
    logic                   valid;
    logic                   done;
    logic                   timeout;
    logic                   busy;

    modport master (
        output hold, ready_read, rx_byte,
        input  payload, valid, done, timeout, busy
    );

    modport slave (
        input  hold, ready_read, rx_byte,
        output payload, valid, done, timeout, busy
    );
endinterface

// File: rtl/cmd_payload_receiver.sv
// Collects NUM_BYTES payload bytes after the command matcher raises hold.
// It assembles the bytes into one word and publishes the word with a single-cycle valid pulse.
// It also pulses done so that the matcher releases hold.
// A collection is abandoned when hold drops early or when the byte stream goes idle too long.
module cmd_payload_receiver #(
    parameter int NUM_BYTES      = 4,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter bit MSB_FIRST      = 1'b1
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    cmd_payload_receiver_if.slave bus
);
    localparam int PW = 8 * NUM_BYTES;
    localparam int CW = $clog2(NUM_BYTES + 1);
    localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] LAST_BYTE  = CW'(NUM_BYTES - 1);
    localparam logic [TW-1:0] TIMER_LAST = (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [TW-1:0] TIMER_MAX  = '1;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        DONE_ST,
        TOUT_ST,
        RELEASE
    } state_t;

    state_t        state, state_next;
    logic          rdy_q;
    logic          strobe;
    logic [CW-1:0] count, count_next;
    logic [TW-1:0] timer, timer_next;
    logic [PW-1:0] shadow, shadow_next, shifted, byte_ext;
    logic [PW-1:0] payload_q, payload_next;
    logic          valid_q, valid_next;
    logic          done_q, done_next;
    logic          timeout_q, timeout_next;
    logic          busy_q, busy_next;

    assign strobe   = bus.ready_read & ~rdy_q;
    assign byte_ext = PW'(bus.rx_byte);
    assign shifted  = MSB_FIRST ? ((shadow << 8) | byte_ext)
                                : ((shadow >> 8) | (byte_ext << (PW - 8)));

    assign bus.payload = payload_q;
    assign bus.valid   = valid_q;
    assign bus.done    = done_q;
    assign bus.timeout = timeout_q;
    assign bus.busy    = busy_q;

    // State and datapath registers; every output is a flop loaded from its next value
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state     <= IDLE;
            rdy_q     <= 1'b0;
            count     <= '0;
            timer     <= '0;
            shadow    <= '0;
            payload_q <= '0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state     <= state_next;
            rdy_q     <= bus.ready_read;
            count     <= count_next;
            timer     <= timer_next;
            shadow    <= shadow_next;
            payload_q <= payload_next;
            valid_q   <= valid_next;
            done_q    <= done_next;
            timeout_q <= timeout_next;
            busy_q    <= busy_next;
        end
    end

    // Next-state selection: in COLLECT, hold loss wins over completion, and completion wins over timeout
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.hold) state_next = COLLECT;
            COLLECT: begin
                if (!bus.hold)
                    state_next = IDLE;
                else if (strobe && count == LAST_BYTE)
                    state_next = DONE_ST;
                else if (!strobe && TIMEOUT_CYCLES != 0 && timer == TIMER_LAST)
                    state_next = TOUT_ST;
            end
            DONE_ST: state_next = RELEASE;
            TOUT_ST: state_next = RELEASE;
            RELEASE: if (!bus.hold) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath updates and output pulses, decoded from the state being entered so they appear registered
    always_comb begin
        count_next   = count;
        timer_next   = timer;
        shadow_next  = shadow;
        payload_next = payload_q;
        case (state)
            IDLE: begin
                count_next  = '0;
                timer_next  = '0;
                shadow_next = '0;
            end
            COLLECT: begin
                if (strobe) begin
                    shadow_next = shifted;
                    count_next  = count + 1'b1;
                    timer_next  = '0;
                end else if (TIMEOUT_CYCLES != 0 && timer != TIMER_MAX) begin
                    timer_next = timer + 1'b1;
                end
            end
            TOUT_ST: shadow_next = '0;
            default: ;
        endcase
        if (state == COLLECT && state_next == DONE_ST)
            payload_next = shifted;
        valid_next   = (state_next == DONE_ST);
        timeout_next = (state_next == TOUT_ST);
        done_next    = (state_next == DONE_ST) || (state_next == TOUT_ST);
        busy_next    = (state_next == COLLECT);
    end
endmodule

// File: tb/tb_cmd_payload_receiver.sv
// Bench for cmd_payload_receiver. Two receivers share one input stream and differ only in byte order.
// A transaction-level reference model predicts every output on every cycle.
module tb_cmd_payload_receiver;
    localparam int NB  = 4;
    localparam int TMO = 50;
    localparam int PW  = 8 * NB;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       hold    = 1'b0;
    logic       rdy     = 1'b0;
    logic [7:0] rx_byte = 8'h00;

    always #5 clk = ~clk;

    cmd_payload_receiver_if #(.NUM_BYTES(NB)) bus_msb ();
    cmd_payload_receiver_if #(.NUM_BYTES(NB)) bus_lsb ();

    assign bus_msb.hold       = hold;
    assign bus_msb.ready_read = rdy;
    assign bus_msb.rx_byte    = rx_byte;
    assign bus_lsb.hold       = hold;
    assign bus_lsb.ready_read = rdy;
    assign bus_lsb.rx_byte    = rx_byte;

    cmd_payload_receiver #(.NUM_BYTES(NB), .TIMEOUT_CYCLES(TMO), .MSB_FIRST(1'b1)) dut_msb (
        .i_clk   (clk),
        .i_reset (rst_n),
        .bus     (bus_msb)
    );

    cmd_payload_receiver #(.NUM_BYTES(NB), .TIMEOUT_CYCLES(TMO), .MSB_FIRST(1'b0)) dut_lsb (
        .i_clk   (clk),
        .i_reset (rst_n),
        .bus     (bus_lsb)
    );

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;

    // Reference model: a collection in progress keeps its bytes in a queue.
    // A one-cycle pulse slot then leads to waiting for hold to fall.
    logic       m_prev       = 1'b0;
    bit         m_collecting = 1'b0;
    bit         m_pulse_slot = 1'b0;
    bit         m_wait_drop  = 1'b0;
    int         m_idle       = 0;
    logic [7:0] m_bytes[$];
    logic [PW-1:0] m_pay_msb = '0;
    logic [PW-1:0] m_pay_lsb = '0;
    logic m_valid = 1'b0, m_done = 1'b0, m_timeout = 1'b0, m_busy = 1'b0;

    int last_edge_cyc = 0, last_valid_cyc = 0, last_tout_cyc = 0;
    int valid_cnt = 0, tout_cnt = 0, done_cnt = 0;
    logic [PW-1:0] seen_pay_msb = '0, seen_pay_lsb = '0;

    task automatic checkOutput(input string name, input logic [PW-1:0] actual, input logic [PW-1:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic modelStep(input logic r, input logic h, input logic d, input logic [7:0] b);
        logic edge_seen;
        m_valid   = 1'b0;
        m_done    = 1'b0;
        m_timeout = 1'b0;
        if (!r) begin
            m_prev = 1'b0; m_collecting = 0; m_pulse_slot = 0; m_wait_drop = 0; m_idle = 0;
            m_bytes.delete();
            m_pay_msb = '0; m_pay_lsb = '0; m_busy = 1'b0;
            return;
        end
        edge_seen = d && !m_prev;
        m_prev = d;
        if (edge_seen) last_edge_cyc = cyc - 1;
        if (m_pulse_slot) begin
            m_pulse_slot = 0;
            m_wait_drop  = 1;
        end else if (m_wait_drop) begin
            if (!h) m_wait_drop = 0;
        end else if (m_collecting) begin
            if (!h) begin
                m_collecting = 0;
            end else if (edge_seen) begin
                m_bytes.push_back(b);
                m_idle = 0;
                if (m_bytes.size() == NB) begin
                    m_pay_msb = '0;
                    m_pay_lsb = '0;
                    for (int i = 0; i < NB; i++) begin
                        m_pay_msb |= PW'(m_bytes[i]) << (8 * (NB - 1 - i));
                        m_pay_lsb |= PW'(m_bytes[i]) << (8 * i);
                    end
                    m_valid = 1'b1; m_done = 1'b1;
                    m_collecting = 0; m_pulse_slot = 1;
                end
            end else begin
                m_idle++;
                if (TMO != 0 && m_idle == TMO) begin
                    m_timeout = 1'b1; m_done = 1'b1;
                    m_collecting = 0; m_pulse_slot = 1;
                end
            end
        end else if (h) begin
            m_collecting = 1;
            m_bytes.delete();
            m_idle = 0;
        end
        m_busy = m_collecting;
    endtask

    // Per-cycle compare of both receivers against the model, sampled 1 ns after the clock edge
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            modelStep(rst_n, hold, rdy, rx_byte);
            #1;
            checkOutput("payload_msb", bus_msb.payload, m_pay_msb);
            checkOutput("payload_lsb", bus_lsb.payload, m_pay_lsb);
            checkOutput("flags_msb", PW'({bus_msb.valid, bus_msb.done, bus_msb.timeout, bus_msb.busy}),
                        PW'({m_valid, m_done, m_timeout, m_busy}));
            checkOutput("flags_lsb", PW'({bus_lsb.valid, bus_lsb.done, bus_lsb.timeout, bus_lsb.busy}),
                        PW'({m_valid, m_done, m_timeout, m_busy}));
            if (bus_msb.valid) begin
                valid_cnt++;
                last_valid_cyc = cyc;
                seen_pay_msb = bus_msb.payload;
                seen_pay_lsb = bus_lsb.payload;
            end
            if (bus_msb.timeout) begin
                tout_cnt++;
                last_tout_cyc = cyc;
            end
            if (bus_msb.done) done_cnt++;
        end
    end

    task automatic applyStimulus(input logic h, input logic r, input logic [7:0] b, input int cycles);
        hold    = h;
        rdy     = r;
        rx_byte = b;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic sendByte(input logic [7:0] b, input int hi, input int lo);
        applyStimulus(hold, 1'b1, b, hi);
        applyStimulus(hold, 1'b0, b, lo);
    endtask

    task automatic sendFour(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3);
        sendByte(b0, 1, 2);
        sendByte(b1, 1, 2);
        sendByte(b2, 1, 2);
        sendByte(b3, 1, 3);
    endtask

    // Directed scenarios with hand-computed expectations, followed by randomized command traffic
    initial begin
        int v0, t0, d0, nb, gap;
        applyStimulus(1'b0, 1'b0, 8'h00, 3);
        checkOutput("reset_payload", bus_msb.payload, '0);
        checkOutput("reset_flags", PW'({bus_msb.valid, bus_msb.done, bus_msb.timeout, bus_msb.busy}), '0);
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 8'h00, 2);

        // A command byte arrives while hold is still low and must not count as payload
        sendByte(8'hC0, 1, 1);
        applyStimulus(1'b1, 1'b0, 8'h00, 2);
        v0 = valid_cnt;
        sendFour(8'h11, 8'h22, 8'h33, 8'h44);
        checkOutput("t1_payload_msb", seen_pay_msb, 32'h11223344);
        checkOutput("t1_payload_lsb", seen_pay_lsb, 32'h44332211);
        checkOutput("t1_model_pin", m_pay_msb, 32'h11223344);
        checkOutput("t1_valid_count", PW'(valid_cnt - v0), 1);
        checkOutput("t1_latency", PW'(last_valid_cyc - last_edge_cyc), 1);
        applyStimulus(1'b0, 1'b0, 8'h00, 3);

        // The first byte is held high for 20 cycles and must be taken only once
        applyStimulus(1'b1, 1'b0, 8'h00, 2);
        v0 = valid_cnt;
        sendByte(8'hA1, 20, 2);
        sendByte(8'hB2, 1, 2);
        sendByte(8'hC3, 1, 2);
        sendByte(8'hD4, 1, 3);
        checkOutput("t3_payload_msb", seen_pay_msb, 32'hA1B2C3D4);
        checkOutput("t3_valid_count", PW'(valid_cnt - v0), 1);
        applyStimulus(1'b0, 1'b0, 8'h00, 3);

        // Two bytes then silence: the timeout pulse comes TMO cycles after the second byte is taken
        applyStimulus(1'b1, 1'b0, 8'h00, 2);
        v0 = valid_cnt; t0 = tout_cnt;
        sendByte(8'h5A, 1, 2);
        sendByte(8'h6B, 1, TMO + 5);
        checkOutput("t4_timeout_count", PW'(tout_cnt - t0), 1);
        checkOutput("t4_valid_count", PW'(valid_cnt - v0), 0);
        checkOutput("t4_delay", PW'(last_tout_cyc - (last_edge_cyc + 1)), TMO);
        checkOutput("t4_payload_kept", bus_msb.payload, 32'hA1B2C3D4);
        applyStimulus(1'b0, 1'b0, 8'h00, 3);

        // Hold drops after two bytes: silent abort, then a full command still works
        applyStimulus(1'b1, 1'b0, 8'h00, 2);
        d0 = done_cnt;
        sendByte(8'h01, 1, 2);
        sendByte(8'h02, 1, 2);
        applyStimulus(1'b0, 1'b0, 8'h00, 3);
        checkOutput("t5_no_done", PW'(done_cnt - d0), 0);
        checkOutput("t5_payload_kept", bus_lsb.payload, 32'hD4C3B2A1);
        applyStimulus(1'b1, 1'b0, 8'h00, 2);
        sendFour(8'h55, 8'h66, 8'h77, 8'h88);
        checkOutput("t5_payload_msb", seen_pay_msb, 32'h55667788);
        checkOutput("t5_payload_lsb", seen_pay_lsb, 32'h88776655);
        applyStimulus(1'b0, 1'b0, 8'h00, 3);

        // Reset after three bytes clears everything, then fresh bytes complete normally
        applyStimulus(1'b1, 1'b0, 8'h00, 2);
        v0 = valid_cnt;
        sendByte(8'h0A, 1, 2);
        sendByte(8'h0B, 1, 2);
        sendByte(8'h0C, 1, 2);
        rst_n = 1'b0;
        applyStimulus(1'b1, 1'b0, 8'h00, 2);
        checkOutput("t6_reset_payload", bus_msb.payload, '0);
        checkOutput("t6_reset_flags", PW'({bus_msb.valid, bus_msb.done, bus_msb.timeout, bus_msb.busy}), '0);
        checkOutput("t6_no_valid", PW'(valid_cnt - v0), 0);
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 8'h00, 2);
        applyStimulus(1'b1, 1'b0, 8'h00, 2);
        sendFour(8'h9A, 8'hBC, 8'hDE, 8'hF0);
        checkOutput("t6_payload_msb", seen_pay_msb, 32'h9ABCDEF0);
        applyStimulus(1'b0, 1'b0, 8'h00, 3);

        // Randomized traffic: gaps near the timeout limit, early hold drops, stray bytes and resets
        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 3) == 0) sendByte(8'($urandom), 1, 1);
            applyStimulus(1'b1, 1'b0, 8'h00, $urandom_range(1, 3));
            nb = $urandom_range(0, 5);
            for (int k = 0; k < nb; k++) begin
                if ($urandom_range(0, 9) == 0) gap = TMO - 2 + $urandom_range(0, 3);
                else gap = $urandom_range(1, 6);
                sendByte(8'($urandom), $urandom_range(1, 4), gap);
                if ($urandom_range(0, 15) == 0) hold = 1'b0;
            end
            if ($urandom_range(0, 19) == 0) begin
                rst_n = 1'b0;
                applyStimulus(hold, 1'b0, 8'h00, 1);
                rst_n = 1'b1;
            end
            applyStimulus(1'b0, 1'b0, 8'h00, $urandom_range(1, 3));
        end

        applyStimulus(1'b0, 1'b0, 8'h00, 3);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
